// File: rtl/pwm_multi_channel_if.sv
// pwm_multi_channel_if
//   Configuration and output bundle for the multi-channel PWM generator.
//   master : register/switch side. It drives the configuration and observes the outputs.
//   slave  : PWM core. It consumes the configuration and drives Y/PeriodStart.
//   Signals:
//     Enable       run (1) / hold counter with outputs inactive (0)
//     Load         strobe that captures Period/Mode/Duty into the shadow registers
//     Period       period setting P
//     Mode         0 = edge-aligned, 1 = centre-aligned
//     Duty         packed per-channel duties; channel i is Duty[i*WIDTH +: WIDTH]
//     Polarity     per-channel output inversion, applied live
//     Y            registered PWM outputs
//     PeriodStart  one-cycle pulse, aligned with the first output cycle of a period
interface pwm_multi_channel_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      Enable;
  logic                      Load;
  logic [WIDTH-1:0]          Period;
  logic                      Mode;
  logic [CHANNELS*WIDTH-1:0] Duty;
  logic [CHANNELS-1:0]       Polarity;
  logic [CHANNELS-1:0]       Y;
  logic                      PeriodStart;

  modport master (
    output Enable, Load, Period, Mode, Duty, Polarity,
    input  Y, PeriodStart
  );

  modport slave (
    input  Enable, Load, Period, Mode, Duty, Polarity,
    output Y, PeriodStart
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
//   Multi-channel PWM generator. A single shared period counter drives CHANNELS
//   compare lanes. Period, mode and duties are double-buffered, so a new setting
//   only becomes active at a period boundary. Polarity is applied live.
//   Ports:
//     Clock   system clock. All logic runs on the posedge.
//     Resetn  synchronous, active-low reset.
//     bus     pwm_multi_channel_if.slave (config in, Y/PeriodStart out)

// pwm_lane: one channel. It holds the pending and active duty registers and the
// registered compare output.
module pwm_lane #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             enable,
  input  logic             pend_wr,        // Load strobe: capture duty_in as pending
  input  logic             act_from_in,    // duty_in goes straight to active
  input  logic             act_from_pend,  // promote pending to active
  input  logic [WIDTH-1:0] duty_in,
  input  logic [WIDTH-1:0] cnt,
  input  logic             polarity,
  output logic             y
);
  logic [WIDTH-1:0] pend_duty;
  logic [WIDTH-1:0] act_duty;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pend_duty <= '0;
      act_duty  <= '0;
      y         <= 1'b0;
    end else begin
      if (pend_wr) pend_duty <= duty_in;
      if (act_from_in)        act_duty <= duty_in;
      else if (act_from_pend) act_duty <= pend_duty;
      // The compare uses the active duty of the current cycle. The active duty only
      // changes on the same edge that restarts cnt, so a period never sees a mix.
      y <= enable ? ((cnt < act_duty) ^ polarity) : polarity;
    end
  end
endmodule

module pwm_multi_channel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                Clock,
  input  logic                Resetn,
  pwm_multi_channel_if.slave  bus
);
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt, cnt_nxt;
  dir_t             dir, dir_nxt;
  logic [WIDTH-1:0] act_p, pend_p;
  logic             act_mode, pend_mode;
  logic             pend_flag;
  logic             first_q;       // current cycle is the first cycle of a period
  logic             boundary;      // current cycle is the last cycle of a period
  logic             act_from_in, act_from_pend;

  logic [CHANNELS-1:0][WIDTH-1:0] duty_in;
  assign duty_in = bus.Duty;

  // Boundary detect. P==0 makes every cycle a boundary. In centre mode with P==1
  // the count never runs down, so the boundary falls on the peak instead.
  always_comb begin
    boundary = 1'b0;
    if (act_p == '0)        boundary = 1'b1;
    else if (!act_mode)     boundary = (cnt == act_p);
    else if (act_p == ONE)  boundary = (cnt == act_p);
    else                    boundary = (dir == DIR_DOWN) && (cnt == ONE);
  end

  // Counter/direction next state. A boundary always restarts at 0 counting up.
  // This also makes dir start clean when the mode switches.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!bus.Enable || boundary) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (!act_mode) begin
      cnt_nxt = cnt + ONE;
      dir_nxt = DIR_UP;
    end else if (dir == DIR_UP) begin
      if (cnt == act_p) begin
        cnt_nxt = cnt - ONE;
        dir_nxt = DIR_DOWN;
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end else begin
      cnt_nxt = cnt - ONE;
    end
  end

  // While the counter is idle, Load writes the active set directly.
  // When running, the active set is updated only at a boundary.
  assign act_from_in   = bus.Load && (!bus.Enable || boundary);
  assign act_from_pend = bus.Enable && boundary && !bus.Load && pend_flag;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt             <= '0;
      dir             <= DIR_UP;
      act_p           <= '1;
      act_mode        <= 1'b0;
      pend_p          <= '0;
      pend_mode       <= 1'b0;
      pend_flag       <= 1'b0;
      first_q         <= 1'b1;
      bus.PeriodStart <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
      if (bus.Load) begin
        pend_p    <= bus.Period;
        pend_mode <= bus.Mode;
      end
      if (act_from_in) begin
        act_p    <= bus.Period;
        act_mode <= bus.Mode;
      end else if (act_from_pend) begin
        act_p    <= pend_p;
        act_mode <= pend_mode;
      end
      // A Load is left pending only if it arrives mid-period while running.
      if (bus.Load)           pend_flag <= bus.Enable && !boundary;
      else if (act_from_pend) pend_flag <= 1'b0;
      // The cycle after a boundary, or the first enabled cycle, starts a period.
      // PeriodStart is delayed one cycle so that it lines up with the registered Y.
      first_q         <= !bus.Enable || boundary;
      bus.PeriodStart <= bus.Enable && first_q;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pwm_lane #(.WIDTH(WIDTH)) u_lane (
      .Clock         (Clock),
      .Resetn        (Resetn),
      .enable        (bus.Enable),
      .pend_wr       (bus.Load),
      .act_from_in   (act_from_in),
      .act_from_pend (act_from_pend),
      .duty_in       (duty_in[i]),
      .cnt           (cnt),
      .polarity      (bus.Polarity[i]),
      .y             (bus.Y[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel
//   Scoreboard bench for pwm_multi_channel. Each cycle, the stimulus process applies
//   inputs and steps a period-position reference model. The model tracks the index k
//   within the period and derives cnt from k. It pushes the expected Y/PeriodStart
//   into a queue. A monitor pops one entry and compares it on every negedge.
module tb_pwm_multi_channel;
  localparam int W  = 8;
  localparam int CH = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #10 clk = ~clk;

  pwm_multi_channel_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(CH)) dut (
    .Clock  (clk),
    .Resetn (rstn),
    .bus    (bus)
  );

  typedef struct {
    logic [CH-1:0] y;
    logic          ps;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // stimulus mirror
  logic          en, ld, md;
  int            per;
  int            duty[CH];
  logic [CH-1:0] pol;

  // reference model state
  int   m_k, m_p, p_p;
  int   m_d[CH], p_d[CH];
  logic m_mode, p_mode, m_flag, m_first;

  task automatic apply();
    bus.Enable   = en;
    bus.Load     = ld;
    bus.Mode     = md;
    bus.Period   = W'(per);
    bus.Polarity = pol;
    for (int i = 0; i < CH; i++) bus.Duty[i*W +: W] = W'(duty[i]);
  endtask

  task automatic load_active();
    m_p = per; m_mode = md;
    for (int i = 0; i < CH; i++) m_d[i] = duty[i];
  endtask

  task automatic load_pending();
    p_p = per; p_mode = md;
    for (int i = 0; i < CH; i++) p_d[i] = duty[i];
  endtask

  task automatic model_step();
    exp_t e;
    int   len, c;
    logic bnd;
    if (!rstn) begin
      m_k = 0; m_p = 255; m_mode = 1'b0; m_flag = 1'b0; m_first = 1'b1;
      for (int i = 0; i < CH; i++) m_d[i] = 0;
      e.y = '0; e.ps = 1'b0;
    end else if (!en) begin
      e.y = pol; e.ps = 1'b0;
      m_k = 0; m_first = 1'b1;
      if (ld) begin load_active(); load_pending(); m_flag = 1'b0; end
    end else begin
      // Period length and counter value follow directly from the position in the period.
      if (m_p == 0)    len = 1;
      else if (m_mode) len = 2 * m_p;
      else             len = m_p + 1;
      c = (m_mode && m_k > m_p) ? 2 * m_p - m_k : m_k;
      for (int i = 0; i < CH; i++) e.y[i] = (c < m_d[i]) ^ pol[i];
      e.ps    = m_first;
      bnd     = (m_k == len - 1);
      m_first = bnd;
      if (bnd) begin
        if (ld) begin load_active(); load_pending(); m_flag = 1'b0; end
        else if (m_flag) begin
          m_p = p_p; m_mode = p_mode;
          for (int i = 0; i < CH; i++) m_d[i] = p_d[i];
          m_flag = 1'b0;
        end
      end else if (ld) begin
        load_pending(); m_flag = 1'b1;
      end
      m_k = bnd ? 0 : m_k + 1;
    end
    q.push_back(e);
  endtask

  task automatic cyc();
    apply();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // monitor
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (bus.Y !== e.y) begin
          n_fail++;
          $display("FAIL Y @%0t: got %b expected %b", $time, bus.Y, e.y);
        end
        n_checks++;
        if (bus.PeriodStart !== e.ps) begin
          n_fail++;
          $display("FAIL PeriodStart @%0t: got %b expected %b", $time, bus.PeriodStart, e.ps);
        end
      end
    end
  end

  initial begin : stim
    int t;
    en = 0; ld = 0; md = 0; per = 0; pol = '0;
    for (int i = 0; i < CH; i++) duty[i] = 0;
    rstn = 0;
    repeat (2) cyc();
    rstn = 1;
    cyc();

    // edge mode P=9: ch0 3/10, ch1 0%, ch2 100%, ch3 inverted 0%
    per = 9; md = 0; duty = '{3, 0, 10, 0}; pol = 4'b1000;
    ld = 1; cyc(); ld = 0;
    en = 1; repeat (25) cyc();

    // mid-period load is deferred to the next boundary
    repeat (3) cyc();
    duty[0] = 7; ld = 1; cyc(); ld = 0;
    repeat (25) cyc();

    // centre mode P=4, duty 2
    md = 1; per = 4; duty[0] = 2; ld = 1; cyc(); ld = 0;
    repeat (30) cyc();

    // disable mid-period, then re-enable
    repeat (3) cyc();
    en = 0; repeat (3) cyc();
    en = 1; repeat (20) cyc();

    // reset with a pending load outstanding
    per = 6; md = 0; duty[0] = 5; ld = 1; cyc(); ld = 0;
    repeat (2) cyc();
    rstn = 0; cyc(); rstn = 1;
    repeat (20) cyc();

    // centre mode corner periods P=1 and P=0
    md = 1; per = 1; duty = '{1, 2, 0, 1}; en = 0; ld = 1; cyc(); ld = 0; en = 1;
    repeat (8) cyc();
    per = 0; ld = 1; cyc(); ld = 0;
    repeat (6) cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rstn = ($urandom_range(199) != 0);
      en   = ($urandom_range(39) != 0);
      ld   = ($urandom_range(11) == 0);
      if (ld) begin
        per = $urandom_range(15);
        md  = $urandom_range(1);
        for (int i = 0; i < CH; i++) duty[i] = $urandom_range(17);
      end
      if ($urandom_range(49) == 0) pol = CH'($urandom);
      cyc();
      ld = 0;
    end

    t = 0;
    while (q.size() > 0 && t < 10) begin
      @(negedge clk); #1; t++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
